// File: rtl/lfsr_step_reg_if.sv
// Signal bundle for the LFSR step engine: injected data, current state and registered result.
// The master drives data and state; the slave (the step engine) returns the next state.
interface lfsr_step_reg_if #(
  parameter int LFSR_WIDTH   = 31,
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = (DATA_WIDTH > LFSR_WIDTH) ? DATA_WIDTH : LFSR_WIDTH
);
  logic [DATA_WIDTH-1:0]   data_in;
  logic [LFSR_WIDTH-1:0]   lfsr_in;
  logic [OUTPUT_WIDTH-1:0] lfsr_out;

  modport master (
    output data_in,
    output lfsr_in,
    input  lfsr_out
  );

  modport slave (
    input  data_in,
    input  lfsr_in,
    output lfsr_out
  );
endinterface

// File: rtl/lfsr_step_reg.sv
// LFSR/CRC/scrambler step engine: advances the state by DATA_WIDTH bit-times per clock,
// injecting data MSB-first, using XOR masks derived from the parameters at elaboration.
module lfsr_step_reg #(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter int                    REVERSE      = 0,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    OUTPUT_WIDTH = (DATA_WIDTH > LFSR_WIDTH) ? DATA_WIDTH : LFSR_WIDTH,
  parameter string                 STYLE        = "AUTO"
) (
  input  logic           clk,
  input  logic           rst_n,
  lfsr_step_reg_if.slave bus
);

  localparam int IN_W      = LFSR_WIDTH + DATA_WIDTH;
  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");
  localparam bit IS_FIB    = (LFSR_CONFIG == "FIBONACCI");
  localparam bit REV       = (REVERSE != 0);
  localparam bit USE_LOOP  = (STYLE == "LOOP");
  localparam bit STYLE_OK  = (STYLE == "LOOP") || (STYLE == "REDUCTION") || (STYLE == "AUTO");

  typedef logic [OUTPUT_WIDTH-1:0][IN_W-1:0] mask_arr_t;

  generate
    if (!IS_GALOIS && !IS_FIB) begin : g_bad_config
      $error("lfsr_step_reg: LFSR_CONFIG must be FIBONACCI or GALOIS");
    end
    if (!STYLE_OK) begin : g_bad_style
      $error("lfsr_step_reg: STYLE must be AUTO, LOOP or REDUCTION");
    end
    if (LFSR_WIDTH < 2 || DATA_WIDTH < 1 || OUTPUT_WIDTH < LFSR_WIDTH) begin : g_bad_width
      $error("lfsr_step_reg: illegal width parameters");
    end
  endgenerate

  // Symbolic bit-serial run: each entry is the set of input bits ({data, state} order)
  // whose XOR forms that bit. hist tracks the state MSBs shifted out, newest at index 0.
  function automatic mask_arr_t calc_masks();
    logic [LFSR_WIDTH-1:0][IN_W-1:0]   st;
    logic [OUTPUT_WIDTH-1:0][IN_W-1:0] hist;
    logic [OUTPUT_WIDTH-1:0][IN_W-1:0] fwd;
    mask_arr_t                         res;
    logic [IN_W-1:0]                   top;
    logic [IN_W-1:0]                   fb;
    st   = '0;
    hist = '0;
    fwd  = '0;
    res  = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      st[i][REV ? (LFSR_WIDTH - 1 - i) : i] = 1'b1;
    end
    for (int step = DATA_WIDTH - 1; step >= 0; step--) begin
      top = st[LFSR_WIDTH-1];
      fb  = top;
      fb[LFSR_WIDTH + (REV ? (DATA_WIDTH - 1 - step) : step)] ^= 1'b1;
      if (!IS_GALOIS) begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) fb ^= st[j-1];
        end
      end
      for (int i = LFSR_WIDTH - 1; i > 0; i--) begin
        st[i] = st[i-1];
      end
      st[0] = fb;
      if (IS_GALOIS) begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) st[j] ^= fb;
        end
      end
      for (int i = OUTPUT_WIDTH - 1; i > 0; i--) begin
        hist[i] = hist[i-1];
      end
      hist[0] = top;
    end
    for (int k = 0; k < OUTPUT_WIDTH; k++) begin
      if (k < LFSR_WIDTH) fwd[k] = st[k];
      else                fwd[k] = hist[k-LFSR_WIDTH];
    end
    for (int k = 0; k < OUTPUT_WIDTH; k++) begin
      res[k] = REV ? fwd[OUTPUT_WIDTH-1-k] : fwd[k];
    end
    return res;
  endfunction

  localparam mask_arr_t MASKS = calc_masks();

  logic [IN_W-1:0]         w_vec;
  logic [OUTPUT_WIDTH-1:0] w_next;
  logic [OUTPUT_WIDTH-1:0] r_lfsr_out;

  assign w_vec = {bus.data_in, bus.lfsr_in};

  generate
    if (USE_LOOP) begin : g_loop
      always_comb begin
        w_next = '0;
        for (int k = 0; k < OUTPUT_WIDTH; k++) begin
          for (int b = 0; b < IN_W; b++) begin
            if (MASKS[k][b]) w_next[k] = w_next[k] ^ w_vec[b];
          end
        end
      end
    end else begin : g_reduction
      for (genvar k = 0; k < OUTPUT_WIDTH; k++) begin : g_bit
        assign w_next[k] = ^(MASKS[k] & w_vec);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr_out <= '0;
    else        r_lfsr_out <= w_next;
  end

  assign bus.lfsr_out = r_lfsr_out;

endmodule

// File: tb/tb_lfsr_step_reg.sv
// Directed bench for lfsr_step_reg: PRBS31 default instance, CRC-32 instance and a
// set of small configurations across STYLE/REVERSE/CONFIG, checked against a bit-serial model.
module tb_lfsr_step_reg;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PRBS31 instance with all default parameters
  lfsr_step_reg_if prbsBus ();
  lfsr_step_reg u_prbs (.clk(clk), .rst_n(rst_n), .bus(prbsBus));

  // CRC-32 instance
  lfsr_step_reg_if #(.LFSR_WIDTH(32), .DATA_WIDTH(8), .OUTPUT_WIDTH(32)) crcBus ();
  lfsr_step_reg #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
    .REVERSE(1), .DATA_WIDTH(8), .OUTPUT_WIDTH(32), .STYLE("AUTO")
  ) u_crc (.clk(clk), .rst_n(rst_n), .bus(crcBus));

  // Small configurations: 16-bit state, 24-bit data, output wider than state
  logic [15:0] rState;
  logic [23:0] rData;
  logic [23:0] rOut [0:5];

  function automatic bit cfgGal(input int k);
    return (k == 0) || (k == 3) || (k == 4);
  endfunction

  function automatic bit cfgRev(input int k);
    return (k % 2) == 1;
  endfunction

  for (genvar k = 0; k < 6; k++) begin : g_cfg
    localparam string S   = (k < 2) ? "LOOP" : ((k < 4) ? "REDUCTION" : "AUTO");
    localparam string C   = ((k == 0) || (k == 3) || (k == 4)) ? "GALOIS" : "FIBONACCI";
    localparam int    R   = k % 2;
    lfsr_step_reg_if #(.LFSR_WIDTH(16), .DATA_WIDTH(24), .OUTPUT_WIDTH(24)) bus ();
    lfsr_step_reg #(
      .LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG(C),
      .REVERSE(R), .DATA_WIDTH(24), .OUTPUT_WIDTH(24), .STYLE(S)
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.data_in = rData;
    assign bus.lfsr_in = rState;
    assign rOut[k]     = bus.lfsr_out;
  end

  function automatic logic [63:0] bitRev(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction

  // Bit-serial reference: one state step per data bit, MSB-first
  function automatic logic [63:0] modelStep(input int L, input int D, input int OW,
                                            input logic [63:0] poly, input bit gal,
                                            input bit rev, input logic [63:0] st,
                                            input logic [63:0] din);
    logic [63:0] s;
    logic [63:0] d;
    logic [63:0] up;
    logic [63:0] res;
    logic [63:0] lmask;
    logic        top;
    logic        fb;
    lmask = (64'h1 << L) - 64'h1;
    s     = rev ? bitRev(st, L) : st;
    d     = rev ? bitRev(din, D) : din;
    up    = '0;
    for (int i = D - 1; i >= 0; i--) begin
      top = s[L-1];
      fb  = top ^ d[i];
      if (!gal) begin
        for (int j = 1; j < L; j++) if (poly[j]) fb = fb ^ s[j-1];
      end
      s = ((s << 1) | 64'(fb)) & lmask;
      if (gal) begin
        for (int j = 1; j < L; j++) if (poly[j]) s[j] = s[j] ^ fb;
      end
      up = (up << 1) | 64'(top);
    end
    res = ((up << L) | s) & ((64'h1 << OW) - 64'h1);
    if (rev) res = bitRev(res, OW);
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [30:0] st, input logic [7:0] d);
    prbsBus.lfsr_in = st;
    prbsBus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [30:0] refState;
  logic [7:0]  refByte;
  logic        refFb;
  logic [31:0] crcExp;
  logic [30:0] held;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    prbsBus.lfsr_in = 31'h7FFFFFFF;
    prbsBus.data_in = 8'h00;
    crcBus.lfsr_in  = 32'hFFFFFFFF;
    crcBus.data_in  = 8'h00;
    rState = 16'hFFFF;
    rData  = 24'hFFFFFF;

    $display("[TB] reset hold");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_prbs", 64'(prbsBus.lfsr_out), 64'h0);
    checkOutput("rst_crc", 64'(crcBus.lfsr_out), 64'h0);
    for (int k = 0; k < 6; k++) checkOutput("rst_cfg", 64'(rOut[k]), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release", 64'(prbsBus.lfsr_out), 64'h7FFFFF00);

    $display("[TB] directed vectors");
    applyStimulus(31'h00000001, 8'h00);
    checkOutput("one_d00", 64'(prbsBus.lfsr_out), 64'h00000100);
    applyStimulus(31'h00000000, 8'h80);
    checkOutput("zero_d80", 64'(prbsBus.lfsr_out), 64'h00000080);
    applyStimulus(31'h00000000, 8'hFF);
    checkOutput("zero_dFF", 64'(prbsBus.lfsr_out), 64'h000000FF);
    applyStimulus(31'h00000000, 8'h00);
    checkOutput("lockup", 64'(prbsBus.lfsr_out), 64'h0);

    held = prbsBus.lfsr_out;
    prbsBus.lfsr_in = 31'h12345678;
    prbsBus.data_in = 8'hA5;
    #2;
    checkOutput("between_edges", 64'(prbsBus.lfsr_out), 64'(held));

    $display("[TB] free-running PRBS31");
    refState = 31'h7FFFFFFF;
    @(negedge clk);
    prbsBus.lfsr_in = 31'h7FFFFFFF;
    prbsBus.data_in = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      refByte = '0;
      for (int b = 0; b < 8; b++) begin
        refFb    = refState[30] ^ refState[27];
        refState = {refState[29:0], refFb};
        refByte  = {refByte[6:0], refFb};
      end
      checkOutput("prbs_state", 64'(prbsBus.lfsr_out), 64'(refState));
      checkOutput("prbs_stream", 64'(prbsBus.lfsr_out[7:0]), 64'(refByte));
      prbsBus.lfsr_in = prbsBus.lfsr_out;
    end

    $display("[TB] asynchronous reset mid-cycle");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 64'(prbsBus.lfsr_out), 64'h0);
    #2;
    rst_n = 1'b1;
    prbsBus.lfsr_in = 31'h7FFFFFFF;
    prbsBus.data_in = 8'h00;
    @(posedge clk);
    #1;
    checkOutput("resume", 64'(prbsBus.lfsr_out), 64'h7FFFFF00);
    prbsBus.lfsr_in = prbsBus.lfsr_out;
    @(posedge clk);
    #1;
    checkOutput("resume2", 64'(prbsBus.lfsr_out),
                modelStep(31, 8, 31, 64'h10000001, 1'b0, 1'b0, 64'h7FFFFF00, 64'h0));

    $display("[TB] CRC-32 of 123456789");
    crcExp = 32'hFFFFFFFF;
    @(negedge clk);
    crcBus.lfsr_in = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      crcBus.data_in = 8'h31 + 8'(i);
      @(posedge clk);
      #1;
      crcExp = 32'(modelStep(32, 8, 32, 64'h04C11DB7, 1'b1, 1'b1, 64'(crcExp), 64'(8'h31 + 8'(i))));
      checkOutput("crc_byte", 64'(crcBus.lfsr_out), 64'(crcExp));
      crcBus.lfsr_in = crcBus.lfsr_out;
    end
    checkOutput("crc_final", 64'(crcBus.lfsr_out ^ 32'hFFFFFFFF), 64'hCBF43926);

    $display("[TB] random vectors across styles");
    for (int n = 0; n < 40; n++) begin
      rState = 16'($urandom());
      rData  = 24'($urandom());
      if (n == 0) begin
        rState = 16'h0000;
        rData  = 24'h000000;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("cfg%0d", k), 64'(rOut[k]),
                    modelStep(16, 24, 24, 64'h1021, cfgGal(k), cfgRev(k), 64'(rState), 64'(rData)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
